// File: rtl/counter_checker_if.sv
// Counter checker bus: observed counter value plus lock/error/statistics.
// master drives the value, slave is the checker.
interface counter_checker_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     value;
  logic                 locked;
  logic                 error;
  logic [CNT_WIDTH-1:0] err_count;
  logic [CNT_WIDTH-1:0] wrap_count;
  logic [WIDTH-1:0]     expected;

  modport master (
    output value,
    input  locked, error, err_count,
    input  wrap_count, expected
  );

  modport slave (
    input  value,
    output locked, error, err_count,
    output wrap_count, expected
  );
endinterface

// File: rtl/counter_checker.sv
// Receive-side monitor for a free-running +1 counter: locks on the
// sequence, then flags breaks and counts errors and wrap-arounds.
module counter_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              reset,
  counter_checker_if.slave bus
);
  typedef enum logic {ACQUIRE, LOCKED} state_t;

  localparam logic [WIDTH-1:0]     ONE     = WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [7:0]           LOCK_N  = 8'(LOCK_COUNT);

  state_t               state, state_n;
  logic [WIDTH-1:0]     prev, prev_inc, exp_q;
  logic                 prev_valid, match;
  logic                 err_q, err_n;
  logic [7:0]           run, run_n, run_inc;
  logic [CNT_WIDTH-1:0] errc, errc_n;
  logic [CNT_WIDTH-1:0] wrapc, wrapc_n;

  assign prev_inc = prev + ONE;
  assign run_inc  = run + 8'd1;
  assign match    = prev_valid &&
                    (bus.value == prev_inc);

  always_comb begin
    state_n = state;
    run_n   = run;
    err_n   = 1'b0;
    errc_n  = errc;
    wrapc_n = wrapc;
    unique case (state)
      ACQUIRE: begin
        if (!match) begin
          run_n = '0;
        end else if (run_inc == LOCK_N) begin
          state_n = LOCKED;
          run_n   = '0;
        end else begin
          run_n = run_inc;
        end
      end
      LOCKED: begin
        if (match) begin
          // match already implies value == 0 here
          if (prev == '1 && wrapc != '1)
            wrapc_n = wrapc + CNT_ONE;
        end else begin
          err_n   = 1'b1;
          state_n = ACQUIRE;
          run_n   = '0;
          if (errc != '1)
            errc_n = errc + CNT_ONE;
        end
      end
      default: state_n = ACQUIRE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ACQUIRE;
      run        <= '0;
      err_q      <= 1'b0;
      errc       <= '0;
      wrapc      <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      exp_q      <= '0;
    end else begin
      state      <= state_n;
      run        <= run_n;
      err_q      <= err_n;
      errc       <= errc_n;
      wrapc      <= wrapc_n;
      prev       <= bus.value;
      prev_valid <= 1'b1;
      exp_q      <= bus.value + ONE;
    end
  end

  assign bus.locked     = (state == LOCKED);
  assign bus.error      = err_q;
  assign bus.err_count  = errc;
  assign bus.wrap_count = wrapc;
  assign bus.expected   = exp_q;
endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: two instances (16-bit and 2-bit stats)
// against a behavioural sequence model, directed plus random stimulus.
module tb_counter_checker;
  localparam int LOCK  = 4;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  counter_checker_if #(.WIDTH(8), .CNT_WIDTH(16)) ifa ();
  counter_checker_if #(.WIDTH(8), .CNT_WIDTH(2))  ifb ();

  counter_checker #(
    .WIDTH(8), .LOCK_COUNT(LOCK), .CNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );

  counter_checker #(
    .WIDTH(8), .LOCK_COUNT(LOCK), .CNT_WIDTH(2)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // model: sample history summarised as lock flag, streak and totals
  bit       m_have;
  bit [7:0] m_prev;
  bit       m_locked;
  int       m_streak;
  bit       m_err;
  int       m_errs;
  int       m_wraps;
  bit [7:0] m_exp;
  bit [7:0] cur;

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have   = 1'b0;
    m_prev   = '0;
    m_locked = 1'b0;
    m_streak = 0;
    m_err    = 1'b0;
    m_errs   = 0;
    m_wraps  = 0;
    m_exp    = '0;
  endtask

  task automatic model_step(input bit [7:0] v);
    bit ok;
    m_err = 1'b0;
    ok = m_have && (v == 8'(m_prev + 8'd1));
    if (m_have) begin
      if (m_locked) begin
        if (ok) begin
          if (v == 8'd0) m_wraps++;
        end else begin
          m_err    = 1'b1;
          m_errs++;
          m_locked = 1'b0;
          m_streak = 0;
        end
      end else begin
        m_streak = ok ? m_streak + 1 : 0;
        if (m_streak == LOCK) begin
          m_locked = 1'b1;
          m_streak = 0;
        end
      end
    end
    m_have = 1'b1;
    m_prev = v;
    m_exp  = v + 8'd1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a.locked", 32'(ifa.locked), 32'(m_locked));
      check("a.error", 32'(ifa.error), 32'(m_err));
      check("a.err_count", 32'(ifa.err_count),
            32'(sat(m_errs, MAX_A)));
      check("a.wrap_count", 32'(ifa.wrap_count),
            32'(sat(m_wraps, MAX_A)));
      check("a.expected", 32'(ifa.expected), 32'(m_exp));
      check("b.locked", 32'(ifb.locked), 32'(m_locked));
      check("b.error", 32'(ifb.error), 32'(m_err));
      check("b.err_count", 32'(ifb.err_count),
            32'(sat(m_errs, MAX_B)));
      check("b.wrap_count", 32'(ifb.wrap_count),
            32'(sat(m_wraps, MAX_B)));
      check("b.expected", 32'(ifb.expected), 32'(m_exp));
    end
  end

  task automatic step(input bit [7:0] v);
    cur = v;
    ifa.value = v;
    ifb.value = v;
    @(posedge clk);
    model_step(v);
    @(negedge clk);
  endtask

  task automatic count_to(input bit [7:0] last);
    while (cur != last) step(cur + 8'd1);
  endtask

  // asserted mid-cycle; outputs must clear before any edge
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst.locked", 32'(ifa.locked), 0);
    check("rst.error", 32'(ifa.error), 0);
    check("rst.err_count", 32'(ifa.err_count), 0);
    check("rst.wrap_count", 32'(ifa.wrap_count), 0);
    check("rst.expected", 32'(ifa.expected), 0);
    check("rst.b_err_count", 32'(ifb.err_count), 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] sat_exp [5];
    bit [7:0] base;
    int r;
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    model_reset();
    ifa.value = '0;
    ifb.value = '0;
    cur = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b0;

    // lock-in from 0
    step(8'h00);
    check("t1.expected0", 32'(ifa.expected), 1);
    step(8'h01);
    step(8'h02);
    step(8'h03);
    check("t1.not_yet", 32'(ifa.locked), 0);
    step(8'h04);
    check("t1.locked", 32'(ifa.locked), 1);
    check("t1.expected", 32'(ifa.expected), 5);

    // two wraps across 513 samples
    count_to(8'hFF);
    check("t2.wrap0", 32'(ifa.wrap_count), 0);
    step(8'h00);
    check("t2.wrap1", 32'(ifa.wrap_count), 1);
    count_to(8'hFF);
    step(8'h00);
    check("t2.wrap2", 32'(ifa.wrap_count), 2);
    check("t2.noerr", 32'(ifa.err_count), 0);

    // counter reset while locked at 0x23
    count_to(8'h23);
    step(8'h00);
    check("t3.error", 32'(ifa.error), 1);
    check("t3.err_count", 32'(ifa.err_count), 1);
    check("t3.unlocked", 32'(ifa.locked), 0);
    step(8'h00);
    check("t3.one_pulse", 32'(ifa.error), 0);
    step(8'h00);
    count_to(8'h03);
    check("t3.relock_wait", 32'(ifa.locked), 0);
    step(8'h04);
    check("t3.relock", 32'(ifa.locked), 1);

    // stall at 0x40
    count_to(8'h40);
    step(8'h40);
    check("t4.error", 32'(ifa.error), 1);
    step(8'h40);
    check("t4.one_pulse", 32'(ifa.error), 0);
    check("t4.err_count", 32'(ifa.err_count), 2);
    count_to(8'h43);
    check("t4.relock_wait", 32'(ifa.locked), 0);
    step(8'h44);
    check("t4.relock", 32'(ifa.locked), 1);

    // third violation, relock, then async reset
    step(8'h80);
    count_to(8'h84);
    check("t5.err_count3", 32'(ifa.err_count), 3);
    check("t5.locked", 32'(ifa.locked), 1);
    do_reset();
    step(8'h10);
    check("t5.first_noerr", 32'(ifa.error), 0);
    check("t5.first_unlocked", 32'(ifa.locked), 0);

    // saturation of the 2-bit error counter
    base = 8'h20;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 5; j++) step(base + 8'(j));
      check("t6.locked", 32'(ifb.locked), 1);
      step(base + 8'd13);
      check("t6.b_error", 32'(ifb.error), 1);
      check("t6.b_err_count", 32'(ifb.err_count),
            32'(sat_exp[k]));
      check("t6.a_err_count", 32'(ifa.err_count), 32'(k + 1));
      base = base + 8'h20;
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 800) step(cur + 8'd1);
      else if (r < 880) step(cur);
      else if (r < 950) step(8'($urandom_range(0, 255)));
      else if (r < 998) step(8'h00);
      else do_reset();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
